// File: rtl/alu_issue_unit.sv
// Single-issue execution front-end for alu_16: decodes one instruction at a time,
// reads operands from an 8x16 register file, drives the ALU handshake and writes results back.
module alu_issue_unit #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic             alu_start,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_done,
    output logic             busy,
    output logic             retire,
    output logic             err,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [WIDTH-1:0] rf_q [8];
    logic [WIDTH-1:0] rf_d [8];
    logic             alu_start_q, alu_start_d;
    logic [2:0]       alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire_q, retire_d;
    logic             err_q, err_d;

    logic             accept;
    logic [WIDTH-1:0] imm_ext;

    assign instr_ready = (state_q == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;
    assign imm_ext     = {{(WIDTH-10){instr_q[9]}}, instr_q[9:0]};

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        rf_d         = rf_q;
        alu_start_d  = 1'b0;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        retire_d     = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    instr_d = instr;
                    if (!instr[15]) begin
                        // ALU outputs are registered here so they are visible during ISSUE
                        state_d      = ISSUE;
                        alu_start_d  = 1'b1;
                        alu_opcode_d = instr[15:13];
                        alu_a_d      = rf_q[instr[9:7]];
                        alu_b_d      = rf_q[instr[6:4]];
                    end else begin
                        state_d  = WB;
                        retire_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    result_d = alu_result;
                    retire_d = 1'b1;
                    state_d  = WB;
                end else if (cnt_q == CNT_LAST) begin
                    err_d    = 1'b1;
                    retire_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                if (instr_q[12:10] != 3'd0) begin
                    if (!instr_q[15]) begin
                        rf_d[instr_q[12:10]] = result_q;
                    end else if (instr_q[15:13] == 3'b100) begin
                        rf_d[instr_q[12:10]] = imm_ext;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
            alu_start_q  <= 1'b0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            retire_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            rf_q         <= rf_d;
            alu_start_q  <= alu_start_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
            retire_q     <= retire_d;
            err_q        <= err_d;
        end
    end

    assign alu_start  = alu_start_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign retire     = retire_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);
    assign dbg_data   = (dbg_addr == 3'd0) ? '0 : rf_q[dbg_addr];

endmodule
